// File: rtl/qtpa_pkg.sv
// Shared scalar-pipe types: opcode enum, EX/WB entry payload and op classification helpers.
package qtpa_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_W  = 4;
  localparam int unsigned FLAGS_W    = 3;

  typedef enum logic [4:0] {
    OP_NOP     = 5'd0,
    OP_ADD_IMM = 5'd1,
    OP_ADD_REG = 5'd2,
    OP_SUB_IMM = 5'd3,
    OP_SUB_REG = 5'd4,
    OP_AND_IMM = 5'd5,
    OP_AND_REG = 5'd6,
    OP_OR_IMM  = 5'd7,
    OP_OR_REG  = 5'd8,
    OP_MOV_IMM = 5'd9,
    OP_MOV_REG = 5'd10,
    OP_SHL_IMM = 5'd11,
    OP_SHL_REG = 5'd12,
    OP_SHR_IMM = 5'd13,
    OP_SHR_REG = 5'd14,
    OP_CMP_IMM = 5'd15,
    OP_CMP_REG = 5'd16,
    OP_LCSET   = 5'd17,
    OP_BRANCH  = 5'd18,
    OP_LOAD    = 5'd19,
    OP_STORE   = 5'd20,
    OP_HALT    = 5'd21
  } op_t;

  localparam int unsigned OP_COUNT = 22;

  typedef struct packed {
    op_t                   op;
    logic [DATA_WIDTH-1:0] result;
    logic                  z;
    logic                  c;
    logic                  v;
    logic [RF_ADDR_W-1:0]  rd;
  } exwb_entry_t;

  // Arithmetic/logic/move/shift ops produce a register result.
  function automatic logic op_writes_rd(op_t op);
    return op inside {OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
                      OP_AND_IMM, OP_AND_REG, OP_OR_IMM,  OP_OR_REG,
                      OP_MOV_IMM, OP_MOV_REG, OP_SHL_IMM, OP_SHL_REG,
                      OP_SHR_IMM, OP_SHR_REG};
  endfunction

  // Compares update flags without writing a register.
  function automatic logic op_sets_flags(op_t op);
    return op_writes_rd(op) || (op inside {OP_CMP_IMM, OP_CMP_REG});
  endfunction

  function automatic logic op_is_lcset(op_t op);
    return op == OP_LCSET;
  endfunction

endpackage

// File: rtl/exwb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main entry is the output register, skid absorbs one overflow.
// SCALAR_EXWB_FWD_EN additionally exposes the skid payload for hazard forwarding.
module exwb_skid_buf #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  input  logic     out_ready,
  output logic     out_valid,
  output payload_t out_data,
  output logic     skid_valid
`ifdef SCALAR_EXWB_FWD_EN
  ,
  output payload_t skid_data
`endif
);

  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     pop;
  logic     push;

  assign in_ready = ~skid_valid_q;
  assign pop      = main_valid_q & out_ready & ~flush;
  assign push     = in_valid & ~skid_valid_q & ~flush;

  // Next-state: refill main from skid first so ordering is preserved.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_data   = main_q;
  assign skid_valid = skid_valid_q;
`ifdef SCALAR_EXWB_FWD_EN
  assign skid_data  = skid_q;
`endif

endmodule

// File: rtl/scalar_exwb_stage.sv
// EX/WB stage: buffers ALU results and performs RF write, flags update and LCSET at commit.
// SCALAR_EXWB_FWD_EN adds fwd_valid/fwd_rd/fwd_data for the decode hazard unit.
module scalar_exwb_stage
  import qtpa_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RF_ADDR_W,
  parameter int unsigned FWD_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  op_t                   in_op,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_flag_zero,
  input  logic                  in_flag_carry,
  input  logic                  in_flag_ovf,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  flush,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  lc_we,
  output logic [DATA_WIDTH-1:0] lc_wdata,
  output logic [FLAGS_W-1:0]    flags_q,
`ifdef SCALAR_EXWB_FWD_EN
  output logic [FWD_DEPTH-1:0]            fwd_valid,
  output logic [FWD_DEPTH*REG_ADDR_W-1:0] fwd_rd,
  output logic [FWD_DEPTH*DATA_WIDTH-1:0] fwd_data,
`endif
  output logic                  busy
);

  exwb_entry_t        in_entry;
  exwb_entry_t        main_entry;
  logic               main_valid;
  logic               skid_valid;
  logic               commit;
  logic [FLAGS_W-1:0] flags_d;
  logic [FWD_DEPTH-1:0] entry_valid;

  always_comb begin
    in_entry        = '0;
    in_entry.op     = in_op;
    in_entry.result = in_result;
    in_entry.z      = in_flag_zero;
    in_entry.c      = in_flag_carry;
    in_entry.v      = in_flag_ovf;
    in_entry.rd     = RF_ADDR_W'(in_rd);
  end

`ifdef SCALAR_EXWB_FWD_EN
  exwb_entry_t skid_entry;
`endif

  exwb_skid_buf #(
    .payload_t (exwb_entry_t)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_entry),
    .out_ready  (rf_ready),
    .out_valid  (main_valid),
    .out_data   (main_entry),
    .skid_valid (skid_valid)
`ifdef SCALAR_EXWB_FWD_EN
    ,
    .skid_data  (skid_entry)
`endif
  );

  // Side effects happen only in the cycle the main entry retires.
  assign commit   = main_valid & rf_ready & ~flush;
  assign rf_we    = commit & op_writes_rd(main_entry.op) & (main_entry.rd != '0);
  assign rf_waddr = REG_ADDR_W'(main_entry.rd);
  assign rf_wdata = main_entry.result;
  assign lc_we    = commit & op_is_lcset(main_entry.op);
  assign lc_wdata = main_entry.result;

  always_comb begin
    flags_d = flags_q;
    if (commit && op_sets_flags(main_entry.op)) begin
      flags_d = {main_entry.z, main_entry.c, main_entry.v};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign entry_valid = FWD_DEPTH'({skid_valid, main_valid});
  assign busy        = |entry_valid;

`ifdef SCALAR_EXWB_FWD_EN
  localparam int unsigned FWD_RD_W   = FWD_DEPTH * REG_ADDR_W;
  localparam int unsigned FWD_DATA_W = FWD_DEPTH * DATA_WIDTH;

  // Index 0 is the older (main) entry, index 1 the younger (skid) entry.
  assign fwd_valid = FWD_DEPTH'({
    skid_valid & op_writes_rd(skid_entry.op) & (skid_entry.rd != '0),
    main_valid & op_writes_rd(main_entry.op) & (main_entry.rd != '0)});
  assign fwd_rd    = FWD_RD_W'({REG_ADDR_W'(skid_entry.rd), REG_ADDR_W'(main_entry.rd)});
  assign fwd_data  = FWD_DATA_W'({skid_entry.result, main_entry.result});
`endif

endmodule

// File: tb/tb_scalar_exwb_stage.sv
// Self-checking bench for scalar_exwb_stage: directed plan steps plus random traffic vs a FIFO reference model.
module tb_scalar_exwb_stage;
  import qtpa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [31:0] in_result;
  logic        in_flag_zero, in_flag_carry, in_flag_ovf;
  logic [3:0]  in_rd;
  logic        flush;
  logic        rf_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lc_we;
  logic [31:0] lc_wdata;
  logic [2:0]  flags_q;
  logic        busy;
`ifdef SCALAR_EXWB_FWD_EN
  logic [1:0]  fwd_valid;
  logic [7:0]  fwd_rd;
  logic [63:0] fwd_data;
`endif

  scalar_exwb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_result     (in_result),
    .in_flag_zero  (in_flag_zero),
    .in_flag_carry (in_flag_carry),
    .in_flag_ovf   (in_flag_ovf),
    .in_rd         (in_rd),
    .flush         (flush),
    .rf_ready      (rf_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .lc_we         (lc_we),
    .lc_wdata      (lc_wdata),
    .flags_q       (flags_q),
`ifdef SCALAR_EXWB_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [31:0] res;
    logic [2:0]  f;
    logic [3:0]  rd;
  } mentry_t;

  mentry_t    q[$];
  logic [2:0] m_flags;
  int         total = 0;
  int         bad   = 0;

  // Architectural classification straight from the op list.
  function automatic bit m_writes(op_t op);
    case (op)
      OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG, OP_AND_IMM, OP_AND_REG,
      OP_OR_IMM, OP_OR_REG, OP_MOV_IMM, OP_MOV_REG, OP_SHL_IMM, OP_SHL_REG,
      OP_SHR_IMM, OP_SHR_REG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_flags_op(op_t op);
    return m_writes(op) || op == OP_CMP_IMM || op == OP_CMP_REG;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already applied; compare, then advance model on the edge.
  task automatic cycle(output bit acc);
    bit commit;
    bit exp_rf, exp_lc;
    #2;
    commit = (q.size() > 0) && rf_ready && !flush;
    acc    = in_valid && (q.size() < 2) && !flush;
    exp_rf = commit && m_writes(q[0].op) && (q[0].rd != 4'd0);
    exp_lc = commit && (q[0].op == OP_LCSET);
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("busy", 64'(busy), 64'(q.size() > 0));
    check("rf_we", 64'(rf_we), 64'(exp_rf));
    check("lc_we", 64'(lc_we), 64'(exp_lc));
    check("flags_q", 64'(flags_q), 64'(m_flags));
    if (exp_rf) begin
      check("rf_waddr", 64'(rf_waddr), 64'(q[0].rd));
      check("rf_wdata", 64'(rf_wdata), 64'(q[0].res));
    end
    if (exp_lc) check("lc_wdata", 64'(lc_wdata), 64'(q[0].res));
`ifdef SCALAR_EXWB_FWD_EN
    for (int i = 0; i < 2; i++) begin
      bit fv;
      fv = (q.size() > i) && m_writes(q[i].op) && (q[i].rd != 4'd0);
      check("fwd_valid", 64'(fwd_valid[i]), 64'(fv));
      if (fv) begin
        check("fwd_rd", 64'(fwd_rd[i*4 +: 4]), 64'(q[i].rd));
        check("fwd_data", 64'(fwd_data[i*32 +: 32]), 64'(q[i].res));
      end
    end
`endif
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (commit) begin
        if (m_flags_op(q[0].op)) m_flags = q[0].f;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{op: in_op, res: in_result,
                             f: {in_flag_zero, in_flag_carry, in_flag_ovf}, rd: in_rd});
    end
  endtask

  task automatic drive(input bit v, input op_t op, input logic [31:0] res, input logic [2:0] f,
                       input logic [3:0] rd, input bit rr, input bit fl, output bit acc);
    in_valid  = v;
    in_op     = op;
    in_result = res;
    {in_flag_zero, in_flag_carry, in_flag_ovf} = f;
    in_rd     = rd;
    rf_ready  = rr;
    flush     = fl;
    cycle(acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, OP_NOP, 32'd0, 3'b000, 4'd0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int tries;
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = OP_NOP; in_result = '0; in_rd = '0;
    {in_flag_zero, in_flag_carry, in_flag_ovf} = 3'b000;
    flush = 1'b0; rf_ready = 1'b1;
    m_flags = 3'b000;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_lc_we", 64'(lc_we), 64'd0);
    check("rst_flags", 64'(flags_q), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with rf_ready held high.
    drive(1'b1, OP_ADD_REG, 32'h0000_0005, 3'b000, 4'd3, 1'b1, 1'b0, acc);
    check("stream_acc0", 64'(acc), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_SUB_IMM, 32'h100 + 32'(i), 3'b010, 4'(i + 4), 1'b1, 1'b0, acc);
      check("stream_acc", 64'(acc), 64'd1);
    end
    idle(2);

    // Backpressure: three ops offered while rf_ready is low.
    drive(1'b1, OP_OR_REG, 32'hA, 3'b000, 4'd1, 1'b0, 1'b0, acc);
    drive(1'b1, OP_AND_IMM, 32'hB, 3'b001, 4'd2, 1'b0, 1'b0, acc);
    drive(1'b1, OP_SHL_REG, 32'hC, 3'b100, 4'd7, 1'b0, 1'b0, acc);
    check("bp_third_held", 64'(acc), 64'd0);
    tries = 0;
    do begin
      drive(1'b1, OP_SHL_REG, 32'hC, 3'b100, 4'd7, 1'b1, 1'b0, acc);
      tries++;
    end while (!acc && tries < 10);
    check("bp_third_accepted", 64'(acc), 64'd1);
    idle(3);

    // Flags: CMP sets flags, LCSET leaves them alone.
    drive(1'b1, OP_CMP_REG, 32'h0, 3'b101, 4'd5, 1'b1, 1'b0, acc);
    idle(1);
    check("cmp_flags", 64'(flags_q), 64'h5);
    drive(1'b1, OP_LCSET, 32'h10, 3'b010, 4'd0, 1'b1, 1'b0, acc);
    idle(1);
    check("lcset_flags", 64'(flags_q), 64'h5);

    // rd=0 write op: flags update, no register write.
    drive(1'b1, OP_MOV_IMM, 32'h7, 3'b010, 4'd0, 1'b1, 1'b0, acc);
    idle(1);
    check("rd0_flags", 64'(flags_q), 64'h2);

    // Flush with both entries full.
    drive(1'b1, OP_ADD_IMM, 32'h11, 3'b111, 4'd8, 1'b0, 1'b0, acc);
    drive(1'b1, OP_LCSET, 32'h22, 3'b000, 4'd9, 1'b0, 1'b0, acc);
    drive(1'b1, OP_MOV_REG, 32'h33, 3'b111, 4'd10, 1'b1, 1'b1, acc);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_flags", 64'(flags_q), 64'h2);
    idle(2);

    // Async reset between edges during backpressure.
    drive(1'b1, OP_ADD_REG, 32'h44, 3'b110, 4'd11, 1'b0, 1'b0, acc);
    drive(1'b1, OP_SUB_REG, 32'h55, 3'b011, 4'd12, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rf_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rf_we", 64'(rf_we), 64'd0);
    check("arst_flags", 64'(flags_q), 64'd0);
    q.delete();
    m_flags = 3'b000;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, op_t'($urandom_range(0, OP_COUNT - 1)), $urandom,
            3'($urandom), 4'($urandom), ($urandom % 4) != 0, ($urandom % 32) == 0, acc);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
